// File: rtl/bp_be_accel_wr_credit.sv
// -----------------------------------------------------------------------------
// bp_be_accel_wr_credit
//
// Credit meter for the accelerator's uncached-write stream. It sits between the
// accelerator pipe's BedRock mem_fwd port and the memory network. Each fwd beat
// is one complete 16B write. The block forwards beats with zero latency while
// fewer than credits_p writes are outstanding. It retires one credit per mem_rev
// response. The backend can issue a fence and wait until every accelerator
// store has been acknowledged.
//
// Protocol errors are sticky until reset, and only the first error's code is
// kept:
//   01 - a response arrived while nothing was outstanding
//   10 - no response for timeout_p-1 cycles while writes were outstanding
//
// Ports
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   fwd_header_i/data_i/v_i   upstream mem_fwd beat
//   fwd_ready_and_o           upstream ready (ready-and)
//   fwd_header_o/data_o/v_o   network mem_fwd beat
//   fwd_ready_and_i           network ready
//   rev_v_i                   mem_rev response valid (header/data unused)
//   rev_ready_and_o           mem_rev ready, 1 whenever out of reset
//   fence_v_i                 fence request (pulse or level)
//   fence_ready_and_o         fence request accepted when high with fence_v_i
//   fence_done_o              one-cycle pulse when the accepted fence drains
//   outstanding_o             writes sent but not yet acknowledged
//   err_o, err_code_o         sticky protocol error and its first cause
// -----------------------------------------------------------------------------
module bp_be_accel_wr_credit #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 128,
    parameter int credits_p      = 8,
    parameter int timeout_p      = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,

    input  logic [header_width_p-1:0]            fwd_header_i,
    input  logic [data_width_p-1:0]              fwd_data_i,
    input  logic                                 fwd_v_i,
    output logic                                 fwd_ready_and_o,

    output logic [header_width_p-1:0]            fwd_header_o,
    output logic [data_width_p-1:0]              fwd_data_o,
    output logic                                 fwd_v_o,
    input  logic                                 fwd_ready_and_i,

    input  logic                                 rev_v_i,
    output logic                                 rev_ready_and_o,

    input  logic                                 fence_v_i,
    output logic                                 fence_ready_and_o,
    output logic                                 fence_done_o,

    output logic [$clog2(credits_p+1)-1:0]       outstanding_o,
    output logic                                 err_o,
    output logic [1:0]                           err_code_o
);

    localparam int ow_lp = $clog2(credits_p + 1);
    localparam int tw_lp = $clog2(timeout_p);

    localparam logic [ow_lp-1:0] credits_lp   = ow_lp'(credits_p);
    localparam logic [tw_lp-1:0] timer_max_lp = tw_lp'(timeout_p - 1);

    localparam logic [1:0] err_none_lp       = 2'b00;
    localparam logic [1:0] err_unexpected_lp = 2'b01;
    localparam logic [1:0] err_timeout_lp    = 2'b10;

    typedef enum logic [1:0] {
        e_run   = 2'b00,
        e_drain = 2'b01,
        e_done  = 2'b10
    } state_e;

    state_e            state_reg;
    logic              fence_ready_reg;
    logic              fence_done_reg;
    logic              rev_ready_reg;

    logic [ow_lp-1:0]  outstanding_reg, outstanding_next;
    logic [tw_lp-1:0]  timer_reg, timer_next;
    logic              err_reg, err_next;
    logic [1:0]        err_code_reg, err_code_next;

    logic              gate;
    logic              send;
    logic              ret;
    logic              unexpected;
    logic              timeout_hit;

    // -------------------------------------------------------------------------
    // Forward path: zero-latency pass-through, gated by credit/FSM/error state.
    // -------------------------------------------------------------------------
    assign gate = (state_reg == e_run) & (outstanding_reg < credits_lp) & ~err_reg;

    assign fwd_header_o    = fwd_header_i;
    assign fwd_data_o      = fwd_data_i;
    assign fwd_v_o         = fwd_v_i & gate;
    assign fwd_ready_and_o = fwd_ready_and_i & gate;

    assign send = fwd_v_o & fwd_ready_and_i;

    // A response only retires a credit if something is outstanding. Otherwise
    // the response is still consumed, and it is flagged unless a send in the
    // same cycle covers it.
    assign ret        = rev_v_i & rev_ready_reg & (outstanding_reg != '0);
    assign unexpected = rev_v_i & rev_ready_reg & (outstanding_reg == '0) & ~send;

    // -------------------------------------------------------------------------
    // Credit counter, response timer and sticky error capture
    // -------------------------------------------------------------------------
    always_comb begin
        outstanding_next = outstanding_reg + ow_lp'(send) - ow_lp'(ret);
    end

    // The timer saturates at its limit so it can never wrap back below it.
    always_comb begin
        timer_next = timer_reg;
        if (ret || (outstanding_reg == '0)) begin
            timer_next = '0;
        end else if (timer_reg != timer_max_lp) begin
            timer_next = timer_reg + tw_lp'(1);
        end
    end

    // Look ahead at timer_next so the error registers in the same cycle that
    // the timer register reaches its limit.
    assign timeout_hit = (timer_next == timer_max_lp);

    always_comb begin
        err_next      = err_reg;
        err_code_next = err_code_reg;
        if (!err_reg) begin
            if (unexpected) begin
                err_next      = 1'b1;
                err_code_next = err_unexpected_lp;
            end else if (timeout_hit) begin
                err_next      = 1'b1;
                err_code_next = err_timeout_lp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            outstanding_reg <= '0;
            timer_reg       <= '0;
            err_reg         <= 1'b0;
            err_code_reg    <= err_none_lp;
            rev_ready_reg   <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            timer_reg       <= timer_next;
            err_reg         <= err_next;
            err_code_reg    <= err_code_next;
            rev_ready_reg   <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Fence FSM with registered handshake outputs.
    // Drain completes on outstanding_next so that a response in the final
    // drain cycle is counted. A timeout never drains, so the fence then waits
    // until reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg       <= e_run;
            fence_ready_reg <= 1'b1;
            fence_done_reg  <= 1'b0;
        end else begin
            fence_done_reg <= 1'b0;
            case (state_reg)
                e_run: begin
                    if (fence_v_i) begin
                        state_reg       <= e_drain;
                        fence_ready_reg <= 1'b0;
                    end
                end
                e_drain: begin
                    if (outstanding_next == '0) begin
                        state_reg      <= e_done;
                        fence_done_reg <= 1'b1;
                    end
                end
                e_done: begin
                    state_reg       <= e_run;
                    fence_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg       <= e_run;
                    fence_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign rev_ready_and_o   = rev_ready_reg;
    assign fence_ready_and_o = fence_ready_reg;
    assign fence_done_o      = fence_done_reg;
    assign outstanding_o     = outstanding_reg;
    assign err_o             = err_reg;
    assign err_code_o        = err_code_reg;

endmodule

// File: tb/tb_bp_be_accel_wr_credit.sv
// -----------------------------------------------------------------------------
// tb_bp_be_accel_wr_credit
//
// Directed bench for the accelerator write-credit meter. Inputs are driven on
// the falling clock edge. Outputs are sampled 1ns later, well before the next
// rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bp_be_accel_wr_credit;

    localparam int HW = 64;
    localparam int DW = 128;
    localparam int CR = 8;
    localparam int TO = 16;
    localparam int OW = $clog2(CR + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [HW-1:0] fwd_header_i;
    logic [DW-1:0] fwd_data_i;
    logic          fwd_v_i;
    logic          fwd_ready_and_o;
    logic [HW-1:0] fwd_header_o;
    logic [DW-1:0] fwd_data_o;
    logic          fwd_v_o;
    logic          fwd_ready_and_i;
    logic          rev_v_i;
    logic          rev_ready_and_o;
    logic          fence_v_i;
    logic          fence_ready_and_o;
    logic          fence_done_o;
    logic [OW-1:0] outstanding_o;
    logic          err_o;
    logic [1:0]    err_code_o;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [HW-1:0] exp_hdr;
    logic [DW-1:0] exp_data;

    bp_be_accel_wr_credit #(
        .header_width_p (HW),
        .data_width_p   (DW),
        .credits_p      (CR),
        .timeout_p      (TO)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .fwd_header_i      (fwd_header_i),
        .fwd_data_i        (fwd_data_i),
        .fwd_v_i           (fwd_v_i),
        .fwd_ready_and_o   (fwd_ready_and_o),
        .fwd_header_o      (fwd_header_o),
        .fwd_data_o        (fwd_data_o),
        .fwd_v_o           (fwd_v_o),
        .fwd_ready_and_i   (fwd_ready_and_i),
        .rev_v_i           (rev_v_i),
        .rev_ready_and_o   (rev_ready_and_o),
        .fence_v_i         (fence_v_i),
        .fence_ready_and_o (fence_ready_and_o),
        .fence_done_o      (fence_done_o),
        .outstanding_o     (outstanding_o),
        .err_o             (err_o),
        .err_code_o        (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Absolute time bound; the directed sequence uses only a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n_i       = 1'b0;
        fwd_header_i    = '0;
        fwd_data_i      = '0;
        fwd_v_i         = 1'b0;
        fwd_ready_and_i = 1'b0;
        rev_v_i         = 1'b0;
        fence_v_i       = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_code", err_code_o, 0);
        chk("rst_fence_done", fence_done_o, 0);
        chk("rst_fence_ready", fence_ready_and_o, 1);
        chk("rst_fwd_v", fwd_v_o, 0);
        chk("rst_rev_ready", rev_ready_and_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("rev_ready_after_rst", rev_ready_and_o, 1);
        @(negedge clk_i);

        // ---------------- burst of 12 against 8 credits ----------------
        fwd_ready_and_i = 1'b1;
        fwd_v_i         = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_hdr      = 64'hA5A5_0000_0000_0000 + 64'(i);
            exp_data     = {64'hDEAD_BEEF_0000_0000 + 64'(i), 64'h0123_4567_89AB_CDEF};
            fwd_header_i = exp_hdr;
            fwd_data_i   = exp_data;
            #1;
            chk("burst_fwd_v", fwd_v_o, (i < 8) ? 1 : 0);
            chk("burst_fwd_ready", fwd_ready_and_o, (i < 8) ? 1 : 0);
            chk("burst_outstanding", outstanding_o, (i < 8) ? i : 8);
            chk("burst_hdr_pass", fwd_header_o, exp_hdr);
            chk("burst_data_pass", fwd_data_o, exp_data);
            @(negedge clk_i);
        end
        rev_v_i = 1'b1;
        #1;
        chk("full_ret_no_reopen", fwd_v_o, 0);
        chk("full_outstanding", outstanding_o, 8);
        @(negedge clk_i);
        rev_v_i = 1'b0;
        #1;
        chk("ninth_outstanding", outstanding_o, 7);
        chk("ninth_fwd_v", fwd_v_o, 1);
        @(negedge clk_i);
        fwd_v_i = 1'b0;
        rev_v_i = 1'b1;
        #1;
        chk("refill_outstanding", outstanding_o, 8);
        repeat (8) @(negedge clk_i);
        rev_v_i = 1'b0;
        #1;
        chk("burst_drained", outstanding_o, 0);
        chk("burst_no_err", err_o, 0);
        @(negedge clk_i);

        // ---------------- steady state at 3 with send+ret ----------------
        fwd_v_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rev_v_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("steady_outstanding", outstanding_o, 3);
            chk("steady_err", err_o, 0);
            chk("steady_fwd_v", fwd_v_o, 1);
            @(negedge clk_i);
        end
        fwd_v_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rev_v_i = 1'b0;
        #1;
        chk("steady_drained", outstanding_o, 0);
        @(negedge clk_i);

        // ---------------- fence at outstanding=5 ----------------
        fwd_v_i = 1'b1;
        repeat (4) @(negedge clk_i);
        fence_v_i = 1'b1;
        #1;
        chk("fence5_accept", fence_ready_and_o, 1);
        chk("fence5_last_send", fwd_v_o, 1);
        @(negedge clk_i);
        fence_v_i = 1'b0;
        for (int k = 0; k < 14; k++) begin
            rev_v_i = (k % 3 == 0) ? 1'b1 : 1'b0;
            #1;
            chk("drain_fwd_v", fwd_v_o, 0);
            chk("drain_outstanding", outstanding_o, 5 - (k + 2) / 3);
            chk("drain_fence_done", fence_done_o, (k == 13) ? 1 : 0);
            chk("drain_fence_ready", fence_ready_and_o, 0);
            @(negedge clk_i);
        end
        rev_v_i = 1'b0;
        #1;
        chk("post_fence_done", fence_done_o, 0);
        chk("post_fence_ready", fence_ready_and_o, 1);
        chk("post_fence_fwd_v", fwd_v_o, 1);
        @(negedge clk_i);
        fwd_v_i = 1'b0;
        rev_v_i = 1'b1;
        #1;
        chk("post_fence_outstanding", outstanding_o, 1);
        @(negedge clk_i);
        rev_v_i = 1'b0;
        #1;
        chk("post_fence_drained", outstanding_o, 0);
        @(negedge clk_i);

        // ---------------- fence at outstanding=0 ----------------
        fence_v_i = 1'b1;
        #1;
        chk("fence0_accept", fence_ready_and_o, 1);
        @(negedge clk_i);
        fence_v_i = 1'b0;
        #1;
        chk("fence0_done_c1", fence_done_o, 0);
        chk("fence0_ready_c1", fence_ready_and_o, 0);
        @(negedge clk_i);
        #1;
        chk("fence0_done_c2", fence_done_o, 1);
        @(negedge clk_i);
        #1;
        chk("fence0_done_c3", fence_done_o, 0);
        chk("fence0_ready_c3", fence_ready_and_o, 1);
        @(negedge clk_i);

        // ---------------- reset in the middle of a drain ----------------
        fwd_v_i = 1'b1;
        repeat (2) @(negedge clk_i);
        fwd_v_i   = 1'b0;
        fence_v_i = 1'b1;
        @(negedge clk_i);
        fence_v_i = 1'b0;
        #1;
        chk("middrain_ready", fence_ready_and_o, 0);
        chk("middrain_outstanding", outstanding_o, 2);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        chk("middrain_rst_outstanding", outstanding_o, 0);
        chk("middrain_rst_ready", fence_ready_and_o, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("middrain_no_done", fence_done_o, 0);
            @(negedge clk_i);
        end

        // ---------------- unexpected response ----------------
        rev_v_i = 1'b1;
        #1;
        chk("unexp_rev_ready", rev_ready_and_o, 1);
        @(negedge clk_i);
        rev_v_i = 1'b0;
        fwd_v_i = 1'b1;
        #1;
        chk("unexp_err", err_o, 1);
        chk("unexp_code", err_code_o, 2'b01);
        chk("unexp_outstanding", outstanding_o, 0);
        chk("unexp_fwd_v_blocked", fwd_v_o, 0);
        chk("unexp_fwd_ready_blocked", fwd_ready_and_o, 0);
        for (int i = 0; i < 20; i++) begin
            rev_v_i = (i == 5) ? 1'b1 : 1'b0;
            #1;
            chk("unexp_hold_code", err_code_o, 2'b01);
            chk("unexp_hold_fwd_v", fwd_v_o, 0);
            @(negedge clk_i);
        end
        rev_v_i   = 1'b0;
        fwd_v_i   = 1'b0;
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        chk("unexp_rst_err", err_o, 0);
        chk("unexp_rst_code", err_code_o, 0);
        @(negedge clk_i);

        // ---------------- timeout (timeout_p=16) ----------------
        fwd_v_i = 1'b1;
        #1;
        chk("to_send", fwd_v_o, 1);
        @(negedge clk_i);
        fwd_v_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("to_err", err_o, (k >= 16) ? 1 : 0);
            chk("to_code", err_code_o, (k >= 16) ? 2'b10 : 2'b00);
            chk("to_outstanding", outstanding_o, 1);
            @(negedge clk_i);
        end
        fwd_v_i = 1'b1;
        rev_v_i = 1'b1;
        #1;
        chk("to_fwd_blocked", fwd_v_o, 0);
        @(negedge clk_i);
        fwd_v_i = 1'b0;
        #1;
        chk("to_rev_outstanding", outstanding_o, 0);
        chk("to_rev_err", err_o, 1);
        chk("to_rev_code", err_code_o, 2'b10);
        @(negedge clk_i);
        rev_v_i = 1'b0;
        #1;
        chk("to_unexp_keeps_code", err_code_o, 2'b10);
        chk("to_unexp_err", err_o, 1);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        chk("final_rst_outstanding", outstanding_o, 0);
        chk("final_rst_err", err_o, 0);
        chk("final_rst_code", err_code_o, 0);
        chk("final_rst_fence_ready", fence_ready_and_o, 1);
        chk("final_rst_fence_done", fence_done_o, 0);
        chk("final_rst_rev_ready", rev_ready_and_o, 0);
        chk("final_rst_fwd_v", fwd_v_o, 0);
        @(negedge clk_i);
        #1;
        chk("final_rev_ready", rev_ready_and_o, 1);
        @(negedge clk_i);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
